// File: rtl/shift_add_mult32.sv
// ---------------------------------------------------------------------------
// shift_add_mult32
//   Sequential unsigned 32x32 shift-and-add multiplier, one partial product
//   accumulated per clock. It serves as the FPU mantissa multiplier.
//   A reset edge starts a new product. The result is final 32 edges later.
//
// Ports
//   clk   in   1   clock, rising edge
//   reset in   1   synchronous active-high; clears state and starts a product
//   opA   in  32   multiplicand (unsigned, must stay stable until done)
//   opB   in  32   multiplier   (unsigned, must stay stable until done)
//   res   out 65   {1'b0, accumulator}
//   done  out  1   high once all 32 partial products have been accumulated
//
// Also contains the datapath primitives: adder64, and64,
// barrel_shifter32 and barrel_shifter64.
// ---------------------------------------------------------------------------

// 64-bit combinational adder; the carry-out is dropped.
module adder64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

// ANDs a 64-bit vector with a broadcast enable bit.
module and64 (
    input  logic [63:0] i_data,
    input  logic        i_en,
    output logic [63:0] o_data
);
    assign o_data = i_data & {64{i_en}};
endmodule

// Logical barrel shifter, 32-bit. i_dir: 1 = right, 0 = left. Zero fill.
module barrel_shifter32 (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_amt,
    input  logic        i_dir,
    output logic [31:0] o_data
);
    logic [5:0][31:0] w_stage;

    assign w_stage[0] = i_data;

    // Stage gi shifts by 2**gi when the matching amount bit is set.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign w_stage[gi+1] = !i_amt[gi] ? w_stage[gi] :
                                   (i_dir ? (w_stage[gi] >> SH) : (w_stage[gi] << SH));
        end
    endgenerate

    assign o_data = w_stage[5];
endmodule

// Logical barrel shifter, 64-bit data and 5-bit amount (0..31).
module barrel_shifter64 (
    input  logic [63:0] i_data,
    input  logic [4:0]  i_amt,
    input  logic        i_dir,
    output logic [63:0] o_data
);
    logic [5:0][63:0] w_stage;

    assign w_stage[0] = i_data;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign w_stage[gi+1] = !i_amt[gi] ? w_stage[gi] :
                                   (i_dir ? (w_stage[gi] >> SH) : (w_stage[gi] << SH));
        end
    endgenerate

    assign o_data = w_stage[5];
endmodule

module shift_add_mult32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [64:0] res,
    output logic        done
);
    logic [5:0]  r_step;
    logic [63:0] r_acc;

    logic [4:0]  w_ct;
    logic [63:0] w_a_sh;
    logic [31:0] w_b_sh;
    logic [63:0] w_partial;
    logic [63:0] w_sum;
    logic        w_unused_bsh;

    // The step counter doubles as the shift amount for both operands.
    assign w_ct = r_step[4:0];

    barrel_shifter64 u_shift_a (
        .i_data ({32'd0, opA}),
        .i_amt  (w_ct),
        .i_dir  (1'b0),
        .o_data (w_a_sh)
    );

    barrel_shifter32 u_shift_b (
        .i_data (opB),
        .i_amt  (w_ct),
        .i_dir  (1'b1),
        .o_data (w_b_sh)
    );

    // Only the LSB of the shifted multiplier selects the partial product.
    assign w_unused_bsh = ^w_b_sh[31:1];

    and64 u_gate (
        .i_data (w_a_sh),
        .i_en   (w_b_sh[0]),
        .o_data (w_partial)
    );

    adder64 u_add (
        .i_a   (r_acc),
        .i_b   (w_partial),
        .o_sum (w_sum)
    );

    // r_step[5] is set only at 32, the terminal count. Once it is set, the
    // accumulator and the counter both hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= 6'd0;
            r_acc  <= 64'd0;
        end else if (!r_step[5]) begin
            r_step <= r_step + 6'd1;
            r_acc  <= w_sum;
        end
    end

    assign done = (r_step == 6'd32);
    assign res  = {1'b0, r_acc};
endmodule

// File: tb/tb_shift_add_mult32.sv
module tb_shift_add_mult32;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [64:0] res;
    logic        done;

    int checks   = 0;
    int failures = 0;

    shift_add_mult32 dut (
        .clk   (clk),
        .reset (reset),
        .opA   (opA),
        .opB   (opB),
        .res   (res),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: after n accumulation edges, the product uses only the low n bits of b.
    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input int n);
        logic [63:0] mask;
        logic [63:0] p;
        if (n >= 32) mask = {64{1'b1}};
        else         mask = (64'd1 << n) - 64'd1;
        p = {32'd0, a} * ({32'd0, b} & mask);
        return {1'b0, p};
    endfunction

    // Checks accumulation edges first..last (inclusive), one negedge per edge.
    task automatic run_steps(input logic [31:0] a, input logic [31:0] b,
                             input int first, input int last);
        for (int n = first; n <= last; n++) begin
            @(negedge clk);
            check("res_step", res, model(a, b, n));
            check("done_step", {64'd0, done}, {64'd0, (n >= 32)});
        end
    endtask

    // Full operation: reset for rst_cycles edges, 32 edges, then `extra` hold edges.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int rst_cycles, input int extra);
        @(negedge clk);
        opA   = a;
        opB   = b;
        reset = 1'b1;
        for (int i = 0; i < rst_cycles; i++) begin
            @(negedge clk);
            check("res_rst", res, 65'd0);
            check("done_rst", {64'd0, done}, 65'd0);
        end
        reset = 1'b0;
        run_steps(a, b, 1, 32);
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            check("res_hold", res, model(a, b, 32));
            check("done_hold", {64'd0, done}, 65'd1);
        end
        $display("op a=%h b=%h res=%h done=%0d", a, b, res, done);
    endtask

    initial begin
        reset = 1'b1;
        opA   = 32'd0;
        opB   = 32'd0;

        // Reset held for 5 cycles, then 5*10; check partial result at edge 5.
        @(negedge clk);
        opA = 32'd5;
        opB = 32'd10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("res_rst5", res, 65'd0);
        end
        reset = 1'b0;
        run_steps(32'd5, 32'd10, 1, 5);
        check("res_5x10_e5", res, 65'd50);
        check("done_5x10_e5", {64'd0, done}, 65'd0);
        run_steps(32'd5, 32'd10, 6, 32);
        check("res_5x10", res, 65'd50);
        check("done_5x10", {64'd0, done}, 65'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("res_5x10_hold", res, 65'd50);
        end
        $display("op a=%h b=%h res=%h done=%0d", 32'd5, 32'd10, res, done);

        // All-ones operands.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2);
        check("res_max", res, {1'b0, 64'hFFFF_FFFE_0000_0001});
        check("res_bit64", {64'd0, res[64]}, 65'd0);

        // Zero multiplier.
        run_op(32'h1234_5678, 32'd0, 1, 1);
        check("res_zero", res, 65'd0);

        // Top shift amount: only the last edge contributes.
        @(negedge clk);
        opA = 32'd1;
        opB = 32'h8000_0000;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_steps(32'd1, 32'h8000_0000, 1, 31);
        check("res_top_e31", res, 65'd0);
        check("done_top_e31", {64'd0, done}, 65'd0);
        @(negedge clk);
        check("res_top_e32", res, 65'h0_8000_0000);
        check("done_top_e32", {64'd0, done}, 65'd1);
        $display("op a=%h b=%h res=%h done=%0d", 32'd1, 32'h8000_0000, res, done);

        // Reset mid-operation, then a full run from the release.
        @(negedge clk);
        opA = 32'd3;
        opB = 32'd7;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_steps(32'd3, 32'd7, 1, 2);
        reset = 1'b1;
        @(negedge clk);
        check("res_midrst", res, 65'd0);
        check("done_midrst", {64'd0, done}, 65'd0);
        reset = 1'b0;
        run_steps(32'd3, 32'd7, 1, 32);
        check("res_3x7", res, 65'd21);
        $display("op a=%h b=%h res=%h done=%0d", 32'd3, 32'd7, res, done);

        // Randomised operands, with occasional narrow multipliers.
        for (int t = 0; t < 120; t++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (t % 4 == 1) b = b >> $urandom_range(31, 0);
            if (t % 7 == 2) a = a & 32'h0000_FFFF;
            run_op(a, b, 1, t % 3);
            check("res_rand", res, {1'b0, 32'd0 + {32'd0, a} * {32'd0, b}});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_add_mult32.md
Name: shift_add_mult32

Overview:
- Sequential unsigned 32x32 multiplier using shift-and-add; one partial product is accumulated per clock.
- Datapath is built from the codebase primitives:
  - adder64: combinational 64-bit add, carry-out discarded.
  - and64: ANDs a 64-bit vector with a broadcast 1-bit enable.
  - barrel_shifter32 / barrel_shifter64: combinational logical shifters with a 5-bit amount and a direction bit (1 = right, 0 = left).
- Sits in the FPU as the mantissa multiplier; the product is valid 32 cycles after reset is released.

Parameters:
None. Operand width is fixed at 32 bits; the accumulator and product are 64 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; starts a new multiplication.
- opA  input  32  multiplicand, unsigned.
- opB  input  32  multiplier, unsigned.
- res  output  65  product; bits [63:0] = accumulator, bit [64] always 0.
- done  output  1  high once all 32 partial products have been accumulated.

Behaviour:
- State:
  - step: 6-bit counter, 0..32.
  - acc: 64-bit accumulator.
- Shift amount ct = step[4:0], used by both shifters.
- Reset (sampled high at a rising edge): step <= 0, acc <= 0. Therefore res = 0 and done = 0 in the cycle after a reset edge.
- Each rising edge with reset low and step < 32:
  - A_SH = zero_extend64(opA) << ct (barrel_shifter64, left, zero fill).
  - B_SH = opB >> ct (barrel_shifter32, right, logical, zero fill).
  - partial = A_SH AND {64{B_SH[0]}} (and64).
  - acc <= acc + partial (adder64, mod 2^64; cannot overflow for 32x32 unsigned).
  - step <= step + 1.
- When step == 32: acc and step hold; done = 1 (combinational from step == 32). No wrap-around, no further accumulation.
- Latency:
  - After N non-reset edges (N <= 32), res = opA * (opB mod 2^N).
  - res is final when done rises: exactly 32 edges after the reset edge.
  - Highest set bit k of opB: res equals the full product after k+1 edges.
- Operands are not latched. opA and opB must stay stable from the reset edge until done. If they change mid-operation, res is the sum of the partial products as computed per cycle; no error is flagged.
- Reset mid-operation: it is synchronous, so it aborts the current product; acc and step clear on that edge and accumulation restarts.
- Reset asserted while done = 1: clears as normal.
- Reset held high: acc and step stay 0.
- Zero operand: res stays 0; done still rises after 32 cycles.
- res[64] is tied to 0.
- No X-propagation requirement before the first reset edge; the bench must apply reset first.

Test Plan:
- Reset high 5 cycles, then release with opA=5, opB=10; wait 5 cycles -> res = 50 (0...0110010), done=0. After 32 total cycles -> res = 50, done=1, and res stays 50 for further cycles.
- opA=0xFFFFFFFF, opB=0xFFFFFFFF, 32 cycles -> res = 0xFFFFFFFE00000001, res[64]=0, done=1.
- opA=0x12345678, opB=0 -> res=0 on every cycle; done=1 after 32 cycles.
- opA=1, opB=0x80000000 -> res=0 after 31 cycles, res=0x80000000 after 32 cycles, done=1 (checks top shift amount ct=31).
- opA=3, opB=7, assert reset at cycle 2 and release -> acc clears on the reset edge; final res=21 exactly 32 cycles after release.
- Random unsigned pairs (>=100) -> res == opA*opB when done=1; res never changes after done.
